// File: rtl/ysyx_040729_csr_unit.sv
// Machine-mode CSR file: mstatus/mie/mip/mtvec/mscratch/mepc/mcause,
// 64-bit mcycle/minstret counters, mhartid, plus trap/interrupt bookkeeping.
`timescale 1ns/1ps
module ysyx_040729_csr_unit #(
    parameter int                    DATA_WIDTH  = 64,
    parameter int                    VECTORED_EN = 1,
    parameter logic [DATA_WIDTH-1:0] MTVEC_RESET = '0,
    parameter logic [DATA_WIDTH-1:0] HART_ID     = '0
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [11:0]           csr_addr,
    input  logic [2:0]            csr_wfunc,
    input  logic [4:0]            csr_uimm,
    input  logic [DATA_WIDTH-1:0] csr_wsrc,
    output logic [DATA_WIDTH-1:0] csr_rdata,
    output logic                  csr_illegal,
    input  logic                  exception,
    input  logic [3:0]            exc_code,
    input  logic [DATA_WIDTH-1:0] exc_pc,
    input  logic                  irq_ack,
    input  logic                  mret,
    input  logic                  instret,
    input  logic                  eirp_i,
    input  logic                  tirp_i,
    input  logic                  sirp_i,
    output logic                  irq_pending,
    output logic [DATA_WIDTH-1:0] irq_cause,
    output logic [DATA_WIDTH-1:0] trap_pc,
    output logic [DATA_WIDTH-1:0] mepc_o
);
    localparam int DW    = DATA_WIDTH;
    localparam bit HI_EN = (DW == 32);
    localparam bit VEC   = (VECTORED_EN != 0);

    // MPP reads as machine mode; on RV64 UXL/SXL-style bits [35:32] read 1010.
    localparam logic [63:0]   MSTATUS_FIXED64 = HI_EN ? 64'h0000_0000_0000_1800
                                                      : 64'h0000_000A_0000_1800;
    localparam logic [DW-1:0] MSTATUS_FIXED   = MSTATUS_FIXED64[DW-1:0];

    localparam logic [11:0] ADDR_MSTATUS   = 12'h300;
    localparam logic [11:0] ADDR_MIE       = 12'h304;
    localparam logic [11:0] ADDR_MTVEC     = 12'h305;
    localparam logic [11:0] ADDR_MSCRATCH  = 12'h340;
    localparam logic [11:0] ADDR_MEPC      = 12'h341;
    localparam logic [11:0] ADDR_MCAUSE    = 12'h342;
    localparam logic [11:0] ADDR_MIP       = 12'h344;
    localparam logic [11:0] ADDR_MCYCLE    = 12'hB00;
    localparam logic [11:0] ADDR_MINSTRET  = 12'hB02;
    localparam logic [11:0] ADDR_MCYCLEH   = 12'hB80;
    localparam logic [11:0] ADDR_MINSTRETH = 12'hB82;
    localparam logic [11:0] ADDR_MHARTID   = 12'hF14;

    // Interrupt bit vectors are packed as [0]=software, [1]=timer, [2]=external,
    // which map to architectural bit positions 3, 7 and 11.
    logic          mst_mie_reg;
    logic          mst_mpie_reg;
    logic [2:0]    mie_reg;
    logic [2:0]    mip_reg;
    logic [DW-3:0] mtvec_base_reg;
    logic          mtvec_mode_reg;
    logic [DW-1:0] mscratch_reg;
    logic [DW-1:0] mepc_reg;
    logic [DW-1:0] mcause_reg;
    logic [63:0]   mcycle_reg;
    logic [63:0]   minstret_reg;
    logic [63:0]   mcycle_next;
    logic [63:0]   minstret_next;

    logic [DW-1:0] mstatus_val;
    logic [DW-1:0] mie_val;
    logic [DW-1:0] mip_val;
    logic [DW-1:0] mtvec_val;
    logic [63:0]   mcycle_hi64;
    logic [63:0]   minstret_hi64;

    logic [DW-1:0] rdata_raw;
    logic          csr_hit;
    logic [DW-1:0] src;
    logic [DW-1:0] wdata;
    logic          wr_req;
    logic          wen;

    logic [2:0]    irq_hits;
    logic [3:0]    irq_code;
    logic [DW-1:0] tvec_base;
    logic          trap_take;
    logic [DW-1:0] trap_cause;

    // Architectural views of the compact state.
    always_comb begin
        mstatus_val    = MSTATUS_FIXED;
        mstatus_val[3] = mst_mie_reg;
        mstatus_val[7] = mst_mpie_reg;
        mie_val        = '0;
        mip_val        = '0;
        for (int i = 0; i < 3; i++) begin
            mie_val[3 + 4 * i] = mie_reg[i];
            mip_val[3 + 4 * i] = mip_reg[i];
        end
    end

    assign mtvec_val     = {mtvec_base_reg, 1'b0, mtvec_mode_reg};
    assign mcycle_hi64   = {32'd0, mcycle_reg[63:32]};
    assign minstret_hi64 = {32'd0, minstret_reg[63:32]};
    assign mepc_o        = mepc_reg;

    // Address decode and read mux (pre-write value).
    always_comb begin
        csr_hit   = 1'b1;
        rdata_raw = '0;
        case (csr_addr)
            ADDR_MSTATUS:  rdata_raw = mstatus_val;
            ADDR_MIE:      rdata_raw = mie_val;
            ADDR_MTVEC:    rdata_raw = mtvec_val;
            ADDR_MSCRATCH: rdata_raw = mscratch_reg;
            ADDR_MEPC:     rdata_raw = mepc_reg;
            ADDR_MCAUSE:   rdata_raw = mcause_reg;
            ADDR_MIP:      rdata_raw = mip_val;
            ADDR_MCYCLE:   rdata_raw = mcycle_reg[DW-1:0];
            ADDR_MINSTRET: rdata_raw = minstret_reg[DW-1:0];
            ADDR_MHARTID:  rdata_raw = HART_ID;
            ADDR_MCYCLEH: begin
                if (HI_EN) rdata_raw = mcycle_hi64[DW-1:0];
                else       csr_hit   = 1'b0;
            end
            ADDR_MINSTRETH: begin
                if (HI_EN) rdata_raw = minstret_hi64[DW-1:0];
                else       csr_hit   = 1'b0;
            end
            default:       csr_hit   = 1'b0;
        endcase
    end

    // Read-modify-write data for csrrw/csrrs/csrrc and their immediate forms.
    assign src = csr_wfunc[2] ? DW'(csr_uimm) : csr_wsrc;

    always_comb begin
        case (csr_wfunc[1:0])
            2'b01:   wdata = src;
            2'b10:   wdata = src | rdata_raw;
            2'b11:   wdata = ~src & rdata_raw;
            default: wdata = rdata_raw;
        endcase
    end

    assign wr_req      = (csr_wfunc[1:0] != 2'b00);
    assign csr_illegal = wr_req && (!csr_hit || (csr_addr[11:10] == 2'b11));
    assign csr_rdata   = csr_illegal ? '0 : rdata_raw;
    assign wen         = wr_req && !csr_illegal;

    // Interrupt arbitration: external beats software beats timer.
    assign irq_hits    = mip_reg & mie_reg;
    assign irq_pending = mst_mie_reg && (|irq_hits);

    always_comb begin
        irq_code = 4'd0;
        if (irq_hits[2])      irq_code = 4'd11;
        else if (irq_hits[0]) irq_code = 4'd3;
        else if (irq_hits[1]) irq_code = 4'd7;
    end

    assign irq_cause = irq_pending ? {1'b1, {(DW-5){1'b0}}, irq_code} : '0;
    assign tvec_base = {mtvec_base_reg, 2'b00};
    assign trap_pc   = (!exception && irq_pending && mtvec_mode_reg)
                     ? tvec_base + DW'({irq_code, 2'b00}) : tvec_base;

    // A synchronous exception takes precedence over an interrupt acknowledge.
    assign trap_take  = exception || irq_ack;
    assign trap_cause = exception ? DW'(exc_code) : irq_cause;

    // Status/enable/vector/scratch/epc/cause: software write first, hardware overrides.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            mst_mie_reg    <= 1'b0;
            mst_mpie_reg   <= 1'b0;
            mie_reg        <= 3'b000;
            mtvec_base_reg <= MTVEC_RESET[DW-1:2];
            mtvec_mode_reg <= VEC ? MTVEC_RESET[0] : 1'b0;
            mscratch_reg   <= '0;
            mepc_reg       <= '0;
            mcause_reg     <= '0;
        end else begin
            if (wen && csr_addr == ADDR_MSTATUS) begin
                mst_mie_reg  <= wdata[3];
                mst_mpie_reg <= wdata[7];
            end
            if (wen && csr_addr == ADDR_MIE)
                mie_reg <= {wdata[11], wdata[7], wdata[3]};
            if (wen && csr_addr == ADDR_MTVEC) begin
                mtvec_base_reg <= wdata[DW-1:2];
                mtvec_mode_reg <= VEC ? wdata[0] : 1'b0;
            end
            if (wen && csr_addr == ADDR_MSCRATCH)
                mscratch_reg <= wdata;
            if (wen && csr_addr == ADDR_MEPC)
                mepc_reg <= wdata & ~DW'(3);
            if (wen && csr_addr == ADDR_MCAUSE)
                mcause_reg <= wdata;

            if (trap_take) begin
                mepc_reg     <= exc_pc & ~DW'(3);
                mcause_reg   <= trap_cause;
                mst_mpie_reg <= mst_mie_reg;
                mst_mie_reg  <= 1'b0;
            end else if (mret) begin
                mst_mie_reg  <= mst_mpie_reg;
                mst_mpie_reg <= 1'b1;
            end
        end
    end

    // Pending bits are plain registered copies of the interrupt lines.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) mip_reg <= 3'b000;
        else        mip_reg <= {eirp_i, tirp_i, sirp_i};
    end

    // Counter next-state: a write to either half loads it and skips the increment.
    always_comb begin
        mcycle_next = mcycle_reg + 64'd1;
        if (wen && (csr_addr == ADDR_MCYCLE || (HI_EN && csr_addr == ADDR_MCYCLEH))) begin
            mcycle_next = mcycle_reg;
            if (csr_addr == ADDR_MCYCLE) mcycle_next[DW-1:0] = wdata;
            else                         mcycle_next[63:32]  = wdata[31:0];
        end
        minstret_next = instret ? minstret_reg + 64'd1 : minstret_reg;
        if (wen && (csr_addr == ADDR_MINSTRET || (HI_EN && csr_addr == ADDR_MINSTRETH))) begin
            minstret_next = minstret_reg;
            if (csr_addr == ADDR_MINSTRET) minstret_next[DW-1:0] = wdata;
            else                           minstret_next[63:32]  = wdata[31:0];
        end
    end

    // Counter registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            mcycle_reg   <= '0;
            minstret_reg <= '0;
        end else begin
            mcycle_reg   <= mcycle_next;
            minstret_reg <= minstret_next;
        end
    end
endmodule

// File: tb/tb_ysyx_040729_csr_unit.sv
// Randomized bench for the CSR unit: an architectural model of the CSR file is
// stepped every clock and compared against the DUT outputs on each falling edge,
// with directed scenarios pinning literal values. A small RV32 instance checks
// the split counter halves and non-vectored mtvec.
`timescale 1ns/1ps
module tb_ysyx_040729_csr_unit;
    localparam logic [63:0] HART  = 64'h7;
    localparam logic [63:0] FIXED = 64'h0000_000A_0000_1800;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [11:0] addr;
    logic [2:0]  wfunc;
    logic [4:0]  uimm;
    logic [63:0] wsrc;
    logic        exc;
    logic [3:0]  code;
    logic [63:0] epc;
    logic        ack, mret, instret, eirp, tirp, sirp;
    logic [63:0] rdata, cause, tpc, mepc;
    logic        illegal, pend;

    logic [11:0] a32;
    logic [2:0]  f32;
    logic [31:0] s32;
    logic [31:0] rdata32, cause32, tpc32, mepc32;
    logic        ill32, pend32;

    ysyx_040729_csr_unit #(.DATA_WIDTH(64), .VECTORED_EN(1), .MTVEC_RESET(64'h0), .HART_ID(HART)) u_dut (
        .clock(clk), .reset(rst_n), .csr_addr(addr), .csr_wfunc(wfunc), .csr_uimm(uimm),
        .csr_wsrc(wsrc), .csr_rdata(rdata), .csr_illegal(illegal), .exception(exc),
        .exc_code(code), .exc_pc(epc), .irq_ack(ack), .mret(mret), .instret(instret),
        .eirp_i(eirp), .tirp_i(tirp), .sirp_i(sirp), .irq_pending(pend), .irq_cause(cause),
        .trap_pc(tpc), .mepc_o(mepc)
    );

    ysyx_040729_csr_unit #(.DATA_WIDTH(32), .VECTORED_EN(0), .MTVEC_RESET(32'h0000_0103), .HART_ID(32'h0)) u_dut32 (
        .clock(clk), .reset(rst_n), .csr_addr(a32), .csr_wfunc(f32), .csr_uimm(5'd0),
        .csr_wsrc(s32), .csr_rdata(rdata32), .csr_illegal(ill32), .exception(1'b0),
        .exc_code(4'd0), .exc_pc(32'd0), .irq_ack(1'b0), .mret(1'b0), .instret(1'b0),
        .eirp_i(1'b0), .tirp_i(1'b0), .sirp_i(1'b0), .irq_pending(pend32), .irq_cause(cause32),
        .trap_pc(tpc32), .mepc_o(mepc32)
    );

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- architectural model ----------------
    logic [63:0] m_status, m_ie, m_ip, m_tvec, m_scratch, m_epc, m_cause, m_cycle, m_instret;

    // {hit, value} of a CSR read
    function automatic logic [64:0] m_read(input logic [11:0] a);
        case (a)
            12'h300: return {1'b1, (m_status & 64'h88) | FIXED};
            12'h304: return {1'b1, m_ie};
            12'h305: return {1'b1, m_tvec};
            12'h340: return {1'b1, m_scratch};
            12'h341: return {1'b1, m_epc};
            12'h342: return {1'b1, m_cause};
            12'h344: return {1'b1, m_ip};
            12'hB00: return {1'b1, m_cycle};
            12'hB02: return {1'b1, m_instret};
            12'hF14: return {1'b1, HART};
            default: return 65'd0;
        endcase
    endfunction

    function automatic logic m_illegal(input logic [11:0] a, input logic [2:0] f);
        logic [64:0] r;
        r = m_read(a);
        return (f[1:0] != 2'b00) && (!r[64] || a[11:10] == 2'b11);
    endfunction

    function automatic logic m_pending();
        return m_status[3] && ((m_ip & m_ie) != 64'd0);
    endfunction

    function automatic logic [63:0] m_code();
        logic [63:0] h;
        h = m_ip & m_ie;
        if (h[11]) return 64'd11;
        if (h[3])  return 64'd3;
        if (h[7])  return 64'd7;
        return 64'd0;
    endfunction

    function automatic logic [63:0] m_cause_out();
        return m_pending() ? (64'h8000_0000_0000_0000 | m_code()) : 64'd0;
    endfunction

    function automatic logic [63:0] m_tpc();
        logic [63:0] base;
        base = m_tvec & ~64'h3;
        if (!exc && m_pending() && m_tvec[0]) return base + 4 * m_code();
        return base;
    endfunction

    logic [64:0] mdl_r;
    logic [63:0] mdl_src, mdl_wd, mdl_old, mdl_irqc;
    bit          mdl_cw, mdl_iw, mdl_legal;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_status = 0; m_ie = 0; m_ip = 0; m_tvec = 0; m_scratch = 0;
            m_epc = 0; m_cause = 0; m_cycle = 0; m_instret = 0;
        end else begin
            mdl_r     = m_read(addr);
            mdl_legal = (wfunc[1:0] != 2'b00) && !m_illegal(addr, wfunc);
            mdl_src   = wfunc[2] ? {59'd0, uimm} : wsrc;
            case (wfunc[1:0])
                2'b01:   mdl_wd = mdl_src;
                2'b10:   mdl_wd = mdl_src | mdl_r[63:0];
                2'b11:   mdl_wd = ~mdl_src & mdl_r[63:0];
                default: mdl_wd = mdl_r[63:0];
            endcase
            mdl_old  = m_status;
            mdl_irqc = m_cause_out();
            mdl_cw   = 0;
            mdl_iw   = 0;
            if (mdl_legal) begin
                case (addr)
                    12'h300: m_status  = mdl_wd & 64'h88;
                    12'h304: m_ie      = mdl_wd & 64'h888;
                    12'h305: m_tvec    = mdl_wd & ~64'h2;
                    12'h340: m_scratch = mdl_wd;
                    12'h341: m_epc     = mdl_wd & ~64'h3;
                    12'h342: m_cause   = mdl_wd;
                    12'hB00: begin m_cycle = mdl_wd; mdl_cw = 1; end
                    12'hB02: begin m_instret = mdl_wd; mdl_iw = 1; end
                    default: ;
                endcase
            end
            if (!mdl_cw) m_cycle = m_cycle + 1;
            if (instret && !mdl_iw) m_instret = m_instret + 1;
            if (exc || ack) begin
                m_epc    = epc & ~64'h3;
                m_cause  = exc ? {60'd0, code} : mdl_irqc;
                m_status = mdl_old[3] ? 64'h80 : 64'h0;
            end else if (mret) begin
                m_status = 64'h80 | (mdl_old[7] ? 64'h8 : 64'h0);
            end
            m_ip = {52'd0, eirp, 3'b000, tirp, 3'b000, sirp, 3'b000};
        end
    end

    // ---------------- per-cycle compare ----------------
    logic [64:0] cmp_r;
    logic        cmp_ill;
    always @(negedge clk) begin
        if (chk_en) begin
            cmp_r   = m_read(addr);
            cmp_ill = m_illegal(addr, wfunc);
            check("cyc_illegal", {63'd0, illegal}, {63'd0, cmp_ill});
            check("cyc_rdata", rdata, cmp_ill ? 64'd0 : cmp_r[63:0]);
            check("cyc_pending", {63'd0, pend}, {63'd0, m_pending()});
            check("cyc_cause", cause, m_cause_out());
            check("cyc_trap_pc", tpc, m_tpc());
            check("cyc_mepc", mepc, m_epc);
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        wfunc = 3'b000; exc = 1'b0; ack = 1'b0; mret = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: got no finish want finish");
        $fatal(1, "timeout");
    end

    logic [11:0] alist [12];

    initial begin
        alist = '{12'h300, 12'h304, 12'h305, 12'h340, 12'h341, 12'h342,
                  12'h344, 12'hB00, 12'hB02, 12'hF14, 12'hB80, 12'h7C0};
        addr = 12'h300; wfunc = 0; uimm = 0; wsrc = 0; exc = 0; code = 0; epc = 0;
        ack = 0; mret = 0; instret = 0; eirp = 0; tirp = 0; sirp = 0;
        a32 = 12'h305; f32 = 0; s32 = 0;
        repeat (2) cyc();
        chk_en = 1'b1;

        // reset state
        #1;
        check("rst_mstatus", rdata, FIXED);
        check("rst_pending", {63'd0, pend}, 64'd0);
        check("rst_mepc", mepc, 64'd0);
        check("rst_trap_pc", tpc, 64'd0);
        rst_n = 1'b1;
        cyc();

        // vectored mtvec, then an exception
        wfunc = 3'b001; addr = 12'h305; wsrc = 64'h8000_0001;
        cyc();
        idle(); exc = 1'b1; code = 4'd2; epc = 64'h1006; addr = 12'h342;
        #1 check("exc_trap_pc", tpc, 64'h8000_0000);
        cyc();
        idle(); addr = 12'h342;
        #1 check("exc_mcause", rdata, 64'd2);
        check("exc_mepc", mepc, 64'h1004);
        addr = 12'h300;
        #1 check("exc_mstatus", rdata, FIXED);

        // interrupt take and return
        wfunc = 3'b110; uimm = 5'd8; addr = 12'h300;
        cyc();
        wfunc = 3'b001; addr = 12'h304; wsrc = 64'h888; eirp = 1; tirp = 1;
        cyc();
        idle(); ack = 1'b1; epc = 64'h2000;
        #1 check("irq_pending", {63'd0, pend}, 64'd1);
        check("irq_cause", cause, 64'h8000_0000_0000_000B);
        check("irq_trap_pc", tpc, 64'h8000_002C);
        cyc();
        idle(); eirp = 0; tirp = 0; addr = 12'h300;
        #1 check("ack_mstatus", rdata, FIXED | 64'h80);
        check("ack_mepc", mepc, 64'h2000);
        addr = 12'h342;
        #1 check("ack_mcause", rdata, 64'h8000_0000_0000_000B);
        mret = 1'b1;
        cyc();
        idle(); addr = 12'h300;
        #1 check("mret_mstatus", rdata, FIXED | 64'h88);

        // csrrc / csrrs immediate on MIE, illegal accesses
        wfunc = 3'b111; uimm = 5'd8;
        cyc();
        idle();
        #1 check("csrrc_mie", rdata, FIXED | 64'h80);
        wfunc = 3'b110;
        cyc();
        idle();
        #1 check("csrrs_mie", rdata, FIXED | 64'h88);
        wfunc = 3'b111;
        cyc();
        idle();
        #1 check("csrrc_mie2", rdata, FIXED | 64'h80);
        wfunc = 3'b001; addr = 12'hF14; wsrc = 64'h99;
        #1 check("hartid_wr_illegal", {63'd0, illegal}, 64'd1);
        check("hartid_wr_rdata", rdata, 64'd0);
        cyc();
        idle();
        #1 check("hartid_read", rdata, HART);
        wfunc = 3'b010; addr = 12'h7C0;
        #1 check("unimpl_wr_illegal", {63'd0, illegal}, 64'd1);
        wfunc = 3'b000;
        #1 check("unimpl_rd_legal", {63'd0, illegal}, 64'd0);
        wfunc = 3'b001; addr = 12'h344;
        #1 check("mip_wr_legal", {63'd0, illegal}, 64'd0);
        cyc();

        // mcycle wrap
        idle(); wfunc = 3'b001; addr = 12'hB00; wsrc = 64'hFFFF_FFFF_FFFF_FFFF;
        cyc();
        idle();
        #1 check("mcycle_load", rdata, 64'hFFFF_FFFF_FFFF_FFFF);
        cyc();
        #1 check("mcycle_wrap0", rdata, 64'd0);
        cyc();
        #1 check("mcycle_wrap1", rdata, 64'd1);

        // trap beats mret and a same-cycle mepc write
        wfunc = 3'b110; uimm = 5'd8; addr = 12'h300;
        cyc();
        wfunc = 3'b001; addr = 12'h340; wsrc = 64'h1234;
        cyc();
        wfunc = 3'b001; addr = 12'h341; wsrc = 64'hDEAD;
        exc = 1'b1; code = 4'd5; epc = 64'h3003; mret = 1'b1;
        cyc();
        idle(); addr = 12'h300;
        #1 check("prio_mepc", mepc, 64'h3000);
        check("prio_mstatus", rdata, FIXED | 64'h80);
        addr = 12'h342;
        #1 check("prio_mcause", rdata, 64'd5);

        // reset asserted in the middle of a trap + write cycle
        exc = 1'b1; epc = 64'h4000; wfunc = 3'b001; addr = 12'h340; wsrc = 64'h55;
        #1 rst_n = 1'b0;
        #1 check("midrst_pending", {63'd0, pend}, 64'd0);
        check("midrst_mepc", mepc, 64'd0);
        check("midrst_mscratch", rdata, 64'd0);
        cyc();
        idle(); rst_n = 1'b1; addr = 12'h305;
        #1 check("midrst_mtvec", rdata, 64'd0);
        addr = 12'h342;
        #1 check("midrst_mcause", rdata, 64'd0);

        // randomized traffic
        for (int n = 0; n < 3000; n++) begin
            cyc();
            if ($urandom_range(0, 13) < 12) addr = alist[$urandom_range(0, 11)];
            else                            addr = 12'($urandom);
            wfunc   = 3'($urandom);
            uimm    = 5'($urandom);
            wsrc    = {$urandom, $urandom};
            exc     = ($urandom_range(0, 15) == 0);
            code    = 4'($urandom);
            epc     = {$urandom, $urandom};
            ack     = ($urandom_range(0, 7) == 0);
            mret    = ($urandom_range(0, 11) == 0);
            instret = 1'($urandom);
            eirp    = ($urandom_range(0, 3) == 0);
            tirp    = ($urandom_range(0, 3) == 0);
            sirp    = ($urandom_range(0, 3) == 0);
        end
        cyc();
        idle(); instret = 0; eirp = 0; tirp = 0; sirp = 0;

        // RV32 instance: non-vectored mtvec and split counters
        a32 = 12'h305; f32 = 3'b000;
        #1 check("rv32_mtvec_rst", {32'd0, rdata32}, 64'h100);
        a32 = 12'h300;
        #1 check("rv32_mstatus", {32'd0, rdata32}, 64'h1800);
        f32 = 3'b001; a32 = 12'h305; s32 = 32'h201;
        cyc();
        f32 = 3'b000;
        #1 check("rv32_mtvec_nomode", {32'd0, rdata32}, 64'h200);
        f32 = 3'b001; a32 = 12'hB00; s32 = 32'd5;
        cyc();
        f32 = 3'b001; a32 = 12'hB80; s32 = 32'd1;
        cyc();
        f32 = 3'b000; a32 = 12'hB00;
        #1 check("rv32_mcycle_lo", {32'd0, rdata32}, 64'd5);
        a32 = 12'hB80;
        #1 check("rv32_mcycleh", {32'd0, rdata32}, 64'd1);
        cyc();
        a32 = 12'hB00;
        #1 check("rv32_mcycle_inc", {32'd0, rdata32}, 64'd6);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
